// File: rtl/systolic_array_os_db.sv
// systolic_array_os_db
//   Output-stationary MxN FP32 tile engine. Each cell owns a pe and a local
//   partial sum; one K-step (A column, B row) is broadcast per handshake.
//   A finished tile is copied into a result buffer and drained one row per
//   valid/ready beat, so the next tile can accumulate during the drain.
//   A per-step watchdog, a sticky timeout flag and a drained-tile counter
//   are included.
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   step_valid/step_ready      K-step handshake; a_row_flat, b_col_flat,
//                              k_first, k_last qualify the step
//   c_row_valid/c_row_ready    result row handshake; c_row_data, c_row_idx,
//                              c_row_last describe the row
//   busy, err_timeout          status; tiles_done counts drained tiles
//   psum_out_flat              last captured pe output per cell (i*N+j)
//   PE_LAT                     pe result latency in cycles (>= 1)

// Per-cell multiply-accumulate: out = psum_in + a*b after LAT cycles.
// Normal numbers only: subnormal operands are treated as zero, overflow
// saturates to infinity. Multiply rounds to nearest-even, add truncates.
module systolic_pe #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] psum_in,
    output logic        out_valid,
    output logic [31:0] out
);
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic [47:0]       p;
        logic [23:0]       f;
        logic signed [9:0] e;
        logic              sgn, rnd, stk;
        sgn = x[31] ^ y[31];
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {sgn, 31'd0};
        p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
        e = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
        if (p[47]) begin
            f = {1'b0, p[46:24]}; rnd = p[23]; stk = |p[22:0]; e = e + 10'sd1;
        end else begin
            f = {1'b0, p[45:23]}; rnd = p[22]; stk = |p[21:0];
        end
        if (rnd && (stk || f[0])) f = f + 24'd1;
        if (f[23]) e = e + 10'sd1;            // rounding carried into the next binade
        if (e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
        if (e <= 10'sd0) return {sgn, 31'd0};
        return {sgn, e[7:0], f[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]       hi, lo;
        logic [7:0]        d;
        logic [24:0]       mh, ml, s;
        logic signed [9:0] e;
        if (x[30:23] == 8'd0) return (y[30:23] == 8'd0) ? 32'd0 : y;
        if (y[30:23] == 8'd0) return x;
        if (x[30:0] >= y[30:0]) begin hi = x; lo = y; end
        else begin hi = y; lo = x; end
        d  = hi[30:23] - lo[30:23];
        mh = {2'b01, hi[22:0]};
        ml = (d > 8'd24) ? 25'd0 : ({2'b01, lo[22:0]} >> d);
        e  = $signed({2'b00, hi[30:23]});
        if (hi[31] == lo[31]) begin
            s = mh + ml;
            if (s[24]) begin s = s >> 1; e = e + 10'sd1; end
        end else begin
            s = mh - ml;
            if (s == 25'd0) return 32'd0;
            for (int i = 0; i < 24; i++)
                if (!s[23]) begin s = s << 1; e = e - 10'sd1; end
        end
        if (e >= 10'sd255) return {hi[31], 8'hFF, 23'd0};
        if (e <= 10'sd0) return {hi[31], 31'd0};
        return {hi[31], e[7:0], s[22:0]};
    endfunction

    logic [LAT-1:0]       vld_q;
    logic [LAT-1:0][31:0] res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            res_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            res_q[0] <= fp_add(psum_in, fp_mul(a, b));
            for (int s = 1; s < LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                res_q[s] <= res_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out       = res_q[LAT-1];
endmodule

module systolic_array_os_db #(
    parameter  int M       = 8,
    parameter  int N       = 8,
    parameter  int TIMEOUT = 64,
    parameter  int CNT_W   = 16,
    parameter  int PE_LAT  = 1,
    localparam int IDX_W   = (M > 1) ? $clog2(M) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 step_valid,
    output logic                 step_ready,
    input  logic [M*32-1:0]      a_row_flat,
    input  logic [N*32-1:0]      b_col_flat,
    input  logic                 k_first,
    input  logic                 k_last,
    output logic                 c_row_valid,
    input  logic                 c_row_ready,
    output logic [N*32-1:0]      c_row_data,
    output logic [IDX_W-1:0]     c_row_idx,
    output logic                 c_row_last,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [CNT_W-1:0]     tiles_done,
    output logic [M*N*32-1:0]    psum_out_flat
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [1:0]          st;
    logic [M-1:0][31:0]  a_lat;
    logic [N-1:0][31:0]  b_lat;
    logic                k_last_lat;
    logic [WD_W-1:0]     wdog;
    logic [M*N-1:0]      done_vec;
    logic [M*N*32-1:0]   psum_flat;
    logic [M*N*32-1:0]   obuf;
    logic                full;
    logic [IDX_W-1:0]    ptr;
    logic                accept, all_done, expire, clr_pv;

    assign step_ready = (st == S_IDLE);
    assign accept     = (st == S_IDLE) && step_valid;
    assign all_done   = &done_vec;
    // done flags are registered, so a cell answering in the last watchdog
    // cycle still counts as late; hence TIMEOUT must leave room for PE_LAT.
    assign expire     = (st == S_WAIT) && !all_done && (wdog == WD_W'(TIMEOUT - 1));
    assign clr_pv     = (accept && k_first) || expire;

    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            localparam int C = i * N + j;
            logic        pe_ov, pv_q, done_q;
            logic [31:0] pe_res, psum_q, dbg_q;

            systolic_pe #(.LAT(PE_LAT)) u_pe (
                .clk      (clk),
                .rst      (rst),
                .in_valid (st == S_LAUNCH),
                .a        (a_lat[i]),
                .b        (b_lat[j]),
                .psum_in  (pv_q ? psum_q : 32'd0),
                .out_valid(pe_ov),
                .out      (pe_res)
            );

            // Results arriving outside S_WAIT belong to an abandoned step.
            always_ff @(posedge clk) begin
                if (rst) begin
                    psum_q <= '0; dbg_q <= '0; pv_q <= 1'b0; done_q <= 1'b0;
                end else begin
                    if (st == S_WAIT && pe_ov) begin
                        psum_q <= pe_res; dbg_q <= pe_res; pv_q <= 1'b1; done_q <= 1'b1;
                    end
                    if (accept) done_q <= 1'b0;
                    if (clr_pv) pv_q <= 1'b0;
                end
            end

            assign done_vec[C]                = done_q;
            assign psum_flat[C*32 +: 32]      = psum_q;
            assign psum_out_flat[C*32 +: 32]  = dbg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= S_IDLE; a_lat <= '0; b_lat <= '0; k_last_lat <= 1'b0; wdog <= '0;
            err_timeout <= 1'b0; full <= 1'b0; ptr <= '0; obuf <= '0; tiles_done <= '0;
        end else begin
            case (st)
                S_IDLE: if (step_valid) begin
                    a_lat <= a_row_flat; b_lat <= b_col_flat; k_last_lat <= k_last;
                    st <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    wdog <= '0;
                    st   <= S_WAIT;
                end
                S_WAIT: begin
                    if (all_done) st <= k_last_lat ? S_COMMIT : S_IDLE;
                    else if (expire) begin
                        err_timeout <= 1'b1;
                        st          <= S_IDLE;
                    end else wdog <= wdog + 1'b1;
                end
                default: if (!full) begin   // S_COMMIT waits for the buffer to empty
                    obuf <= psum_flat; full <= 1'b1; ptr <= '0;
                    st   <= S_IDLE;
                end
            endcase

            // Commit only touches full/ptr while empty, drain only while full.
            if (full && c_row_ready) begin
                if (ptr == IDX_W'(M - 1)) begin
                    full <= 1'b0; ptr <= '0; tiles_done <= tiles_done + 1'b1;
                end else ptr <= ptr + 1'b1;
            end
        end
    end

    assign c_row_valid = full;
    assign c_row_data  = full ? obuf[int'(ptr)*N*32 +: N*32] : '0;
    assign c_row_idx   = ptr;
    assign c_row_last  = full && (ptr == IDX_W'(M - 1));
    assign busy        = (st != S_IDLE) || full;
endmodule

// File: tb/tb_systolic_array_os_db.sv
module tb_systolic_array_os_db;
    localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000,
                            F4 = 32'h40800000, F5 = 32'h40A00000, F6 = 32'h40C00000,
                            F7 = 32'h40E00000, F8 = 32'h41000000, F9 = 32'h41100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // main DUT: 2x2, pe latency 2
    logic        rst, step_valid, step_ready, k_first, k_last;
    logic [63:0] a_row_flat, b_col_flat, c_row_data;
    logic        c_row_valid, c_row_ready, c_row_last, busy, err_timeout;
    logic [0:0]  c_row_idx;
    logic [15:0] tiles_done;
    logic [127:0] psum_out_flat;

    systolic_array_os_db #(.M(2), .N(2), .TIMEOUT(8), .CNT_W(16), .PE_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(step_ready),
        .a_row_flat(a_row_flat), .b_col_flat(b_col_flat), .k_first(k_first), .k_last(k_last),
        .c_row_valid(c_row_valid), .c_row_ready(c_row_ready), .c_row_data(c_row_data),
        .c_row_idx(c_row_idx), .c_row_last(c_row_last), .busy(busy),
        .err_timeout(err_timeout), .tiles_done(tiles_done), .psum_out_flat(psum_out_flat)
    );

    // slow DUT: pe answers after 20 cycles, watchdog expires after 8
    logic        s_rst, s_step_valid, s_step_ready, s_k_first, s_k_last;
    logic [63:0] s_a_row_flat, s_b_col_flat, s_c_row_data;
    logic        s_c_row_valid, s_c_row_ready, s_c_row_last, s_busy, s_err_timeout;
    logic [0:0]  s_c_row_idx;
    logic [15:0] s_tiles_done;
    logic [127:0] s_psum_out_flat;

    systolic_array_os_db #(.M(2), .N(2), .TIMEOUT(8), .CNT_W(16), .PE_LAT(20)) u_slow (
        .clk(clk), .rst(s_rst), .step_valid(s_step_valid), .step_ready(s_step_ready),
        .a_row_flat(s_a_row_flat), .b_col_flat(s_b_col_flat), .k_first(s_k_first), .k_last(s_k_last),
        .c_row_valid(s_c_row_valid), .c_row_ready(s_c_row_ready), .c_row_data(s_c_row_data),
        .c_row_idx(s_c_row_idx), .c_row_last(s_c_row_last), .busy(s_busy),
        .err_timeout(s_err_timeout), .tiles_done(s_tiles_done), .psum_out_flat(s_psum_out_flat)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Present one K-step on the main DUT; returns at the negedge after acceptance.
    task automatic do_step(input logic [63:0] a, input logic [63:0] b, input logic kf, input logic kl);
        int n = 0;
        while (!step_ready && n < 100) begin @(negedge clk); n++; end
        if (!step_ready) begin
            checks++; errors++;
            $display("FAIL step_accept: step_ready stuck low for %0d cycles", n);
        end
        step_valid = 1'b1; a_row_flat = a; b_col_flat = b; k_first = kf; k_last = kl;
        @(negedge clk);
        step_valid = 1'b0; k_first = 1'b0; k_last = 1'b0;
    endtask

    // Wait (bounded) for a result row, sample it, then step past the handshake edge.
    task automatic wait_row(output logic [63:0] d, output logic [0:0] idx, output logic last,
                            output bit ok, output int n);
        n = 0;
        while (!c_row_valid && n < 100) begin @(negedge clk); n++; end
        ok = c_row_valid; d = c_row_data; idx = c_row_idx; last = c_row_last;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; step_valid = 1'b0; a_row_flat = '0; b_col_flat = '0;
        k_first = 1'b0; k_last = 1'b0; c_row_ready = 1'b1;
        s_rst = 1'b1; s_step_valid = 1'b0; s_a_row_flat = '0; s_b_col_flat = '0;
        s_k_first = 1'b0; s_k_last = 1'b0; s_c_row_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (step_ready !== 1'b1) begin errors++; $display("FAIL reset_step_ready: got %b want 1", step_ready); end
        checks++; if (c_row_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", c_row_valid); end
        checks++; if (c_row_data !== 64'd0 || c_row_idx !== 1'b0 || c_row_last !== 1'b0) begin
            errors++; $display("FAIL reset_row: data %h idx %0d last %b want 0", c_row_data, c_row_idx, c_row_last); end
        checks++; if (busy !== 1'b0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_status: busy %b err %b want 0 0", busy, err_timeout); end
        checks++; if (tiles_done !== 16'd0 || psum_out_flat !== 128'd0) begin
            errors++; $display("FAIL reset_counters: tiles %0d psum %h want 0", tiles_done, psum_out_flat); end
        checks++; if (s_step_ready !== 1'b1 || s_err_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_slow: ready %b err %b want 1 0", s_step_ready, s_err_timeout); end
        rst = 1'b0; s_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_tile();
        logic [63:0] d; logic [0:0] idx; logic last; bit ok; int n;
        c_row_ready = 1'b1;
        do_step({F2, F1}, {F4, F3}, 1'b1, 1'b1);
        wait_row(d, idx, last, ok, n);
        // launch +1, pe 2, done reg +1, commit +1
        checks++; if (n !== 5) begin errors++; $display("FAIL single_latency: got %0d cycles want 5", n); end
        checks++; if (!ok || d !== {F4, F3} || idx !== 1'b0 || last !== 1'b0) begin
            errors++; $display("FAIL single_row0: ok %b data %h idx %0d last %b want %h 0 0", ok, d, idx, last, {F4, F3}); end
        wait_row(d, idx, last, ok, n);
        checks++; if (!ok || d !== {F8, F6} || idx !== 1'b1 || last !== 1'b1) begin
            errors++; $display("FAIL single_row1: ok %b data %h idx %0d last %b want %h 1 1", ok, d, idx, last, {F8, F6}); end
        checks++; if (tiles_done !== 16'd1 || busy !== 1'b0 || c_row_valid !== 1'b0) begin
            errors++; $display("FAIL single_done: tiles %0d busy %b valid %b want 1 0 0", tiles_done, busy, c_row_valid); end
        checks++; if (psum_out_flat !== {F8, F6, F4, F3}) begin
            errors++; $display("FAIL single_debug: got %h want %h", psum_out_flat, {F8, F6, F4, F3}); end
    endtask

    task automatic test_k_accum();
        logic [63:0] d; logic [0:0] idx; logic last; bit ok; int n;
        do_step({F2, F1}, {F4, F3}, 1'b1, 1'b0);
        do_step({F1, F1}, {F1, F1}, 1'b0, 1'b1);
        wait_row(d, idx, last, ok, n);
        checks++; if (!ok || d !== {F5, F4} || idx !== 1'b0) begin
            errors++; $display("FAIL kacc_row0: ok %b data %h idx %0d want %h 0", ok, d, idx, {F5, F4}); end
        wait_row(d, idx, last, ok, n);
        checks++; if (!ok || d !== {F9, F7} || idx !== 1'b1 || last !== 1'b1) begin
            errors++; $display("FAIL kacc_row1: ok %b data %h idx %0d want %h 1", ok, d, idx, {F9, F7}); end
        // fresh tile must not carry the previous sums
        do_step({F1, F1}, {F1, F1}, 1'b1, 1'b1);
        wait_row(d, idx, last, ok, n);
        checks++; if (!ok || d !== {F1, F1} || idx !== 1'b0) begin
            errors++; $display("FAIL kfirst_row0: ok %b data %h want %h", ok, d, {F1, F1}); end
        wait_row(d, idx, last, ok, n);
        checks++; if (!ok || d !== {F1, F1} || idx !== 1'b1) begin
            errors++; $display("FAIL kfirst_row1: ok %b data %h want %h", ok, d, {F1, F1}); end
        checks++; if (tiles_done !== 16'd3) begin errors++; $display("FAIL kacc_tiles: got %0d want 3", tiles_done); end
    endtask

    task automatic test_ready_stall();
        logic [63:0] d; logic [0:0] idx; logic last; bit ok; int n;
        c_row_ready = 1'b0;
        do_step({F2, F1}, {F4, F3}, 1'b1, 1'b1);
        n = 0;
        while (!c_row_valid && n < 100) begin @(negedge clk); n++; end
        for (int c = 0; c < 10; c++) begin
            checks++; if (c_row_valid !== 1'b1 || c_row_data !== {F4, F3} || c_row_idx !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: valid %b data %h idx %0d want 1 %h 0", c, c_row_valid, c_row_data, c_row_idx, {F4, F3}); end
            @(negedge clk);
        end
        checks++; if (tiles_done !== 16'd3) begin errors++; $display("FAIL stall_tiles: got %0d want 3", tiles_done); end
        c_row_ready = 1'b1;
        wait_row(d, idx, last, ok, n);
        checks++; if (!ok || d !== {F4, F3} || idx !== 1'b0) begin
            errors++; $display("FAIL stall_row0: ok %b data %h idx %0d", ok, d, idx); end
        wait_row(d, idx, last, ok, n);
        checks++; if (!ok || d !== {F8, F6} || idx !== 1'b1 || last !== 1'b1) begin
            errors++; $display("FAIL stall_row1: ok %b data %h idx %0d", ok, d, idx); end
        checks++; if (tiles_done !== 16'd4) begin errors++; $display("FAIL stall_tiles_end: got %0d want 4", tiles_done); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d; logic [0:0] idx; logic last; bit ok; int n;
        logic [63:0] exp_d [4];
        exp_d[0] = {F1, F1}; exp_d[1] = {F1, F1}; exp_d[2] = {F4, F3}; exp_d[3] = {F8, F6};
        c_row_ready = 1'b0;
        do_step({F1, F1}, {F1, F1}, 1'b1, 1'b1);
        do_step({F2, F1}, {F4, F3}, 1'b1, 1'b1);
        repeat (12) @(negedge clk);
        checks++; if (step_ready !== 1'b0 || busy !== 1'b1 || c_row_valid !== 1'b1 || c_row_data !== {F1, F1}) begin
            errors++; $display("FAIL b2b_park: ready %b busy %b valid %b data %h want 0 1 1 %h", step_ready, busy, c_row_valid, c_row_data, {F1, F1}); end
        c_row_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wait_row(d, idx, last, ok, n);
            checks++; if (!ok || d !== exp_d[r] || idx !== 1'(r % 2) || last !== 1'(r % 2)) begin
                errors++; $display("FAIL b2b_row%0d: ok %b data %h idx %0d last %b want %h %0d", r, ok, d, idx, last, exp_d[r], r % 2); end
        end
        checks++; if (tiles_done !== 16'd6 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_tiles: tiles %0d busy %b want 6 0", tiles_done, busy); end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit saw_row = 1'b0;
        s_step_valid = 1'b1; s_a_row_flat = {F2, F1}; s_b_col_flat = {F4, F3};
        s_k_first = 1'b1; s_k_last = 1'b1;
        @(negedge clk);
        s_step_valid = 1'b0;
        while (!s_err_timeout && n < 40) begin @(negedge clk); n++; end
        // one launch cycle plus eight S_WAIT cycles
        checks++; if (s_err_timeout !== 1'b1 || n !== 9) begin
            errors++; $display("FAIL timeout_fire: err %b after %0d cycles want 1 after 9", s_err_timeout, n); end
        checks++; if (s_step_ready !== 1'b1 || s_busy !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: ready %b busy %b want 1 0", s_step_ready, s_busy); end
        for (int c = 0; c < 30; c++) begin
            if (s_c_row_valid) saw_row = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_row || s_tiles_done !== 16'd0) begin
            errors++; $display("FAIL timeout_norow: row seen %b tiles %0d want 0 0", saw_row, s_tiles_done); end
        checks++; if (s_psum_out_flat !== 128'd0 || s_err_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_stale: psum %h err %b want 0 1", s_psum_out_flat, s_err_timeout); end
    endtask

    task automatic test_reset_drain();
        logic [63:0] d; logic [0:0] idx; logic last; bit ok; int n;
        bit saw_row = 1'b0;
        c_row_ready = 1'b1;
        do_step({F2, F1}, {F4, F3}, 1'b1, 1'b1);
        wait_row(d, idx, last, ok, n);
        checks++; if (!ok || d !== {F4, F3} || c_row_valid !== 1'b1 || c_row_idx !== 1'b1) begin
            errors++; $display("FAIL rstd_row1: ok %b data %h valid %b idx %0d", ok, d, c_row_valid, c_row_idx); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (c_row_valid !== 1'b0 || tiles_done !== 16'd0 || err_timeout !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstd_clear: valid %b tiles %0d err %b busy %b want 0", c_row_valid, tiles_done, err_timeout, busy); end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c_row_valid) saw_row = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_row) begin errors++; $display("FAIL rstd_dropped: row emitted after reset"); end
        do_step({F2, F1}, {F1, F1}, 1'b1, 1'b1);
        wait_row(d, idx, last, ok, n);
        checks++; if (!ok || d !== {F1, F1} || idx !== 1'b0) begin
            errors++; $display("FAIL rstd_fresh0: ok %b data %h want %h", ok, d, {F1, F1}); end
        wait_row(d, idx, last, ok, n);
        checks++; if (!ok || d !== {F2, F2} || idx !== 1'b1 || last !== 1'b1) begin
            errors++; $display("FAIL rstd_fresh1: ok %b data %h want %h", ok, d, {F2, F2}); end
        checks++; if (tiles_done !== 16'd1) begin errors++; $display("FAIL rstd_tiles: got %0d want 1", tiles_done); end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_k_accum();
        test_ready_stall();
        test_back_to_back();
        test_timeout();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
